// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, formatter state encoding and the
// nibble-to-ASCII hex helper.
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEX  = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_formatter.sv
// Formats accepted binary words as uppercase ASCII hex (MS nibble first, optional
// CR LF) and writes them into the TX FIFO byte port, never writing while full.
module uart_hex_formatter
    import uart_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit ADD_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic              busy
);

    localparam int NIBBLES = DATA_W / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES - 1);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]    cnt_reg,   cnt_next;

    // Handshake and write strobe are gated by rst so nothing leaves the block
    // during the reset cycle even though the registers still hold old state.
    assign busy     = (state_reg != ST_IDLE);
    assign in_ready = !busy && !rst;
    assign tx_wr    = busy && !fifo_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    shift_next = in_data;
                    cnt_next   = CNT_LOAD;
                    state_next = ST_HEX;
                end
            end
            ST_HEX: begin
                if (tx_wr) begin
                    shift_next = shift_reg << 4;
                    cnt_next   = cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0)
                        state_next = ADD_CRLF ? ST_CR : ST_IDLE;
                end
            end
            ST_CR: begin
                if (tx_wr)
                    state_next = ST_LF;
            end
            ST_LF: begin
                if (tx_wr)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Character decode uses registered state only, so it holds steady while stalled.
    always_comb begin
        tx_data = 8'h00;
        case (state_reg)
            ST_HEX:  tx_data = nib2ascii(shift_reg[DATA_W-1 -: 4]);
            ST_CR:   tx_data = ASCII_CR;
            ST_LF:   tx_data = ASCII_LF;
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Bench for uart_hex_formatter: directed literal sequences plus a randomized run
// checked every cycle against a queue-based formatting model.
module tb_uart_hex_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_full;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        busy;

    logic [7:0]  in8_data;
    logic        in8_valid;
    logic        in8_ready;
    logic        full8;
    logic [7:0]  tx8_data;
    logic        tx8_wr;
    logic        busy8;

    always #5 clk = ~clk;

    uart_hex_formatter #(.DATA_W(16), .ADD_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fifo_full(fifo_full), .tx_data(tx_data),
        .tx_wr(tx_wr), .busy(busy)
    );

    uart_hex_formatter #(.DATA_W(8), .ADD_CRLF(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_data(in8_data), .in_valid(in8_valid),
        .in_ready(in8_ready), .fifo_full(full8), .tx_data(tx8_data),
        .tx_wr(tx8_wr), .busy(busy8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference formatting: hex digits of the word, MS nibble first, then CR LF.
    function automatic void format_word(input logic [15:0] w, inout logic [7:0] bq[$]);
        for (int i = 3; i >= 0; i--) begin
            int n;
            n = int'((w >> (4 * i)) & 16'hF);
            bq.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
        end
        bq.push_back(8'h0D);
        bq.push_back(8'h0A);
    endfunction

    logic [7:0] exp_q[$];
    bit         mon_en = 0;
    int         n_acc = 0;
    int         n_pushed = 0;
    int         n_dropped = 0;
    int         n_wr = 0;

    // Model update on each edge: reset discards, a write consumes, a handshake appends.
    always @(posedge clk) begin
        if (mon_en) begin
            if (rst) begin
                n_dropped += exp_q.size();
                exp_q.delete();
            end else begin
                if (tx_wr && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_wr++;
                end else if (tx_wr) begin
                    n_wr++;
                end
                if (in_valid && in_ready) begin
                    format_word(in_data, exp_q);
                    n_pushed += 6;
                    n_acc++;
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] exp_d;
            logic       pend;
            pend  = (exp_q.size() != 0);
            exp_d = pend ? exp_q[0] : 8'h00;
            chk("mon_busy", 32'(busy), 32'(pend));
            chk("mon_in_ready", 32'(in_ready), 32'(!pend && !rst));
            chk("mon_tx_wr", 32'(tx_wr), 32'(pend && !fifo_full && !rst));
            chk("mon_tx_data", 32'(tx_data), 32'(exp_d));
            chk("mon_no_write_when_full", 32'(tx_wr && fifo_full), 32'd0);
        end
    end

    // Apply one cycle of inputs (called #1 after a rising edge), check mid-cycle.
    task automatic step(input logic v, input logic [15:0] d, input logic f, input logic r,
                        input logic ew, input logic [7:0] et, input logic er, input string nm);
        in_valid  = v;
        in_data   = d;
        fifo_full = f;
        rst       = r;
        @(negedge clk);
        chk({nm, "_tx_wr"}, 32'(tx_wr), 32'(ew));
        chk({nm, "_tx_data"}, 32'(tx_data), 32'(et));
        chk({nm, "_in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pin_q[$];
        logic [7:0] lit_a[6];
        int         cyc;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; fifo_full = 1'b0;
        in8_valid = 1'b0; in8_data = '0; full8 = 1'b0;

        // Pin the model against hand-computed byte strings.
        lit_a = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        format_word(16'hBEEF, pin_q);
        for (int i = 0; i < 6; i++) chk("model_pin_beef", 32'(pin_q[i]), 32'(lit_a[i]));
        pin_q.delete();
        format_word(16'h09C0, pin_q);
        chk("model_pin_09c0_d0", 32'(pin_q[0]), 32'h30);
        chk("model_pin_09c0_d2", 32'(pin_q[2]), 32'h43);

        @(posedge clk);
        #1;
        mon_en = 1;
        step(0, 16'h0, 0, 1, 0, 8'h00, 0, "reset");
        chk("reset_busy", 32'(busy), 32'd0);
        step(0, 16'h0, 0, 0, 0, 8'h00, 1, "post_reset");

        // 0x1A2F unstalled.
        step(1, 16'h1A2F, 0, 0, 0, 8'h00, 1, "w1a2f_acc");
        step(0, 16'h0, 0, 0, 1, 8'h31, 0, "w1a2f_c1");
        step(0, 16'h0, 0, 0, 1, 8'h41, 0, "w1a2f_c2");
        step(0, 16'h0, 0, 0, 1, 8'h32, 0, "w1a2f_c3");
        step(0, 16'h0, 0, 0, 1, 8'h46, 0, "w1a2f_c4");
        step(0, 16'h0, 0, 0, 1, 8'h0D, 0, "w1a2f_c5");
        step(0, 16'h0, 0, 0, 1, 8'h0A, 0, "w1a2f_c6");
        step(0, 16'h0, 0, 0, 0, 8'h00, 1, "w1a2f_c7");

        // 0x1A2F with a 3-cycle stall after the second write.
        step(1, 16'h1A2F, 0, 0, 0, 8'h00, 1, "stall_acc");
        step(0, 16'h0, 0, 0, 1, 8'h31, 0, "stall_c1");
        step(0, 16'h0, 0, 0, 1, 8'h41, 0, "stall_c2");
        step(0, 16'h0, 1, 0, 0, 8'h32, 0, "stall_f1");
        step(0, 16'h0, 1, 0, 0, 8'h32, 0, "stall_f2");
        step(0, 16'h0, 1, 0, 0, 8'h32, 0, "stall_f3");
        step(0, 16'h0, 0, 0, 1, 8'h32, 0, "stall_c3");
        step(0, 16'h0, 0, 0, 1, 8'h46, 0, "stall_c4");
        step(0, 16'h0, 0, 0, 1, 8'h0D, 0, "stall_c5");
        step(0, 16'h0, 0, 0, 1, 8'h0A, 0, "stall_c6");
        step(0, 16'h0, 0, 0, 0, 8'h00, 1, "stall_end");

        // in_valid held across two words: 0x0000 then 0xFFFF, 14 cycles.
        step(1, 16'h0000, 0, 0, 0, 8'h00, 1, "b2b_acc0");
        for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 0, 0, 1, 8'h30, 0, "b2b_w0_hex");
        step(1, 16'hFFFF, 0, 0, 1, 8'h0D, 0, "b2b_w0_cr");
        step(1, 16'hFFFF, 0, 0, 1, 8'h0A, 0, "b2b_w0_lf");
        step(1, 16'hFFFF, 0, 0, 0, 8'h00, 1, "b2b_acc1");
        for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 0, 1, 8'h46, 0, "b2b_w1_hex");
        step(0, 16'h0, 0, 0, 1, 8'h0D, 0, "b2b_w1_cr");
        step(0, 16'h0, 0, 0, 1, 8'h0A, 0, "b2b_w1_lf");
        step(0, 16'h0, 0, 0, 0, 8'h00, 1, "b2b_end");

        // Reset mid-word after the second character of 0xBEEF, then 0x0001.
        step(1, 16'hBEEF, 0, 0, 0, 8'h00, 1, "rst_acc");
        step(0, 16'h0, 0, 0, 1, 8'h42, 0, "rst_c1");
        step(0, 16'h0, 0, 0, 1, 8'h45, 0, "rst_c2");
        step(0, 16'h0, 0, 1, 0, 8'h45, 0, "rst_pulse");
        step(1, 16'h0001, 0, 0, 0, 8'h00, 1, "rst_acc2");
        step(0, 16'h0, 0, 0, 1, 8'h30, 0, "rst_n1");
        step(0, 16'h0, 0, 0, 1, 8'h30, 0, "rst_n2");
        step(0, 16'h0, 0, 0, 1, 8'h30, 0, "rst_n3");
        step(0, 16'h0, 0, 0, 1, 8'h31, 0, "rst_n4");
        step(0, 16'h0, 0, 0, 1, 8'h0D, 0, "rst_n5");
        step(0, 16'h0, 0, 0, 1, 8'h0A, 0, "rst_n6");
        step(0, 16'h0, 0, 0, 0, 8'h00, 1, "rst_end");

        // 8-bit, no CRLF instance: 0x09 -> "09".
        in8_valid = 1'b1; in8_data = 8'h09;
        @(negedge clk);
        chk("w8_ready", 32'(in8_ready), 32'd1);
        @(posedge clk); #1;
        in8_valid = 1'b0;
        @(negedge clk);
        chk("w8_c1_wr", 32'(tx8_wr), 32'd1);
        chk("w8_c1_data", 32'(tx8_data), 32'h30);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_c2_wr", 32'(tx8_wr), 32'd1);
        chk("w8_c2_data", 32'(tx8_data), 32'h39);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_idle_wr", 32'(tx8_wr), 32'd0);
        chk("w8_idle_busy", 32'(busy8), 32'd0);
        chk("w8_idle_ready", 32'(in8_ready), 32'd1);
        chk("w8_idle_data", 32'(tx8_data), 32'h00);
        @(posedge clk); #1;

        // Randomized run: 1000 further words with random back-pressure.
        begin
            int target;
            target = n_acc + 1000;
            cyc = 0;
            while (n_acc < target && cyc < 40000) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                in_data   = 16'($urandom);
                fifo_full = ($urandom_range(0, 9) < 3);
                @(posedge clk); #1;
                cyc++;
            end
            chk("rand_word_budget", 32'(n_acc >= target), 32'd1);
        end
        in_valid = 1'b0; fifo_full = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("drain_idle", 32'(busy), 32'd0);
        chk("byte_count", 32'(n_wr), 32'(n_pushed - n_dropped));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_hex_formatter.md
# uart_hex_formatter

Upstream feeder for the UART transmit path: accepts binary words over a valid/ready handshake and writes them as uppercase ASCII hex, most significant nibble first, optionally followed by CR LF, into the byte-write port of the TX FIFO (`data` / `wr_req` / `fifo_full`). It gives the SDR a human-readable debug and telemetry stream without software formatting. It never writes into a full FIFO.

## Interface
- `DATA_W`, 16: input word width in bits; must be a multiple of 4, range 4..64.
- `ADD_CRLF`, 1: 1 appends 0x0D 0x0A after each word; 0 emits hex characters only.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_W  word to format; sampled on accept.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `fifo_full`  in  1  TX FIFO full flag, driven directly by the FIFO.
- `tx_data`  out  8  ASCII byte to the FIFO `data` port.
- `tx_wr`  out  1  FIFO write strobe, to `wr_req`.
- `busy`  out  1  high while a captured word is being emitted.

## Operation
- State machine: IDLE, HEX, CR, LF.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture `in_data` into the shift register, load nibble counter with DATA_W/4 − 1, go to HEX.
- HEX: current character = ASCII of the top nibble of the shift register.
  - 0–9 → 0x30–0x39.
  - A–F → 0x41–0x46.
  - Each cycle with `tx_wr` = 1: shift the register left by 4 and decrement the counter.
  - When the write happens with counter = 0: go to CR if ADD_CRLF = 1, else IDLE.
- CR: character 0x0D; on write go to LF.
- LF: character 0x0A; on write go to IDLE.
- `tx_wr` = (state ≠ IDLE) && !`fifo_full` && !`rst`.
  - Combinational on the registered state and the `fifo_full` input, so that a write is never issued in a cycle where the FIFO reports full.
  - The state advances only in cycles with `tx_wr` = 1.
- `tx_data` depends only on registered state. It is stable while stalled and is 0x00 in IDLE.
- `busy` = (state ≠ IDLE).
- Back-pressure: `fifo_full` held high freezes the state and the shift register indefinitely. No character is dropped or repeated.
- Simultaneous events:
  - `in_valid` is ignored outside IDLE (`in_ready` = 0). The upstream must hold the word.
  - `fifo_full` deasserting and asserting on successive cycles gives exactly one write per non-full cycle.
- Reset, including mid-word: state goes to IDLE and the partially emitted word is discarded. No completion of CR/LF; the next word starts fresh.
- Reset values of outputs:
  - `in_ready` is 0 while `rst` is high and 1 on the first cycle after `rst` falls.
  - `tx_wr` is 0.
  - `tx_data` is 0x00.
  - `busy` is 0.

## Timing
- Word accepted at edge t → first `tx_wr` at cycle t+1 if the FIFO is not full.
- Unstalled word: DATA_W/4 + 2·ADD_CRLF consecutive write cycles. For DATA_W = 16 with CRLF: 6 writes.
- Return to IDLE is on the edge after the last write. `in_ready` = 1 on that cycle.
- Minimum period per word is therefore writes + 1 cycles (7 for the default configuration).
- No combinational path from `in_valid` to any output.

## Structure
- Shared package `uart_pkg`:
  - ASCII constants: `ASCII_0` = 0x30, `ASCII_A` = 0x41, `ASCII_CR` = 0x0D, `ASCII_LF` = 0x0A.
  - State encoding for IDLE/HEX/CR/LF.
  - Function `nib2ascii` (4-bit in, 8-bit out).
- No sub-module. Single module: shift register, nibble counter, 2-bit FSM, output decode.
- Top-level integration: `tx_data`/`tx_wr` connect to the TX module's `data`/`wr_req`; `fifo_full` returns from it.

## Test plan
- Default parameters, `fifo_full` = 0, `in_data` = 0x1A2F accepted at t → `tx_wr` high at t+1..t+6 with `tx_data` 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A; `in_ready` high at t+7.
- Same word, `fifo_full` high for 3 cycles immediately after the second write → no writes for 3 cycles, `tx_data` held at 0x32, then 0x32, 0x46, 0x0D, 0x0A; exactly 6 writes in total.
- `in_valid` held high with 0x0000 then 0xFFFF → "0000\r\n" followed by "FFFF\r\n"; second word accepted only on the `in_ready` cycle; 14 cycles in total.
- `rst` pulsed for 1 cycle after the second character of 0xBEEF → no write during reset; IDLE next; the following word 0x0001 emits "0001\r\n" with no residue of 0xBEEF.
- DATA_W = 8, ADD_CRLF = 0, word 0x09 → exactly 2 writes, 0x30 then 0x39; back to IDLE.
- Scoreboard over 1000 random words with random `fifo_full` → byte stream equals the reference formatting; `tx_wr` never high while `fifo_full` is high.
